// File: rtl/servile_wb_rr_arbiter_pkg.sv
// servile_wb_rr_arbiter_pkg
//   Shared definitions for the Wishbone round-robin arbiter:
//   FSM state encoding, Wishbone field widths and a helper that sizes the
//   round-robin pointer for 2..4 masters.
package servile_wb_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    // Pointer width for NUM_M masters (NUM_M is limited to 2..4).
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/servile_wb_rr_arbiter_pick.sv
// servile_rr_pick
//   Combinational rotating priority encoder. Scans the request vector
//   starting at (ptr_i+1) mod NUM_M, wrapping, and returns a one-hot
//   grant for the first requester found (all zero if none).
//   Ports:
//     req_i  [NUM_M]  request vector
//     ptr_i  [PW]     index of the most recently served master
//     gnt_o  [NUM_M]  one-hot grant
module servile_rr_pick #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned PW    = 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [NUM_M-1:0] gnt_o
);

    int unsigned idx;

    // Walk from the farthest offset down to the nearest so the last hit,
    // i.e. the one closest after ptr_i, is what remains in gnt_o.
    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int unsigned i = NUM_M; i >= 1; i--) begin
            idx = (int'(ptr_i) + i) % NUM_M;
            if (req_i[idx[PW-1:0]]) begin
                gnt_o                = '0;
                gnt_o[idx[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/servile_wb_rr_arbiter.sv
// servile_wb_rr_arbiter
//   Registered round-robin arbiter sharing one Wishbone-classic slave
//   between NUM_M masters. One transaction outstanding at a time; the
//   grant is held until slave ack, master stb drop, or timeout, then the
//   priority rotates past the master just served.
//   Ports:
//     i_clk, i_rst_n        clock, synchronous active-low reset
//     i_wb_m_*              packed per-master request fields (master k at slice k)
//     o_wb_m_rdt            slave read data broadcast to all masters
//     o_wb_m_ack/err        per-master ack (combinational) / timeout error pulse
//     o_wb_s_*              muxed slave request, all zero in IDLE
//     i_wb_s_rdt/ack        slave response
//     o_grant               registered one-hot grant, zero in IDLE
module servile_wb_rr_arbiter
    import servile_wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M   = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_M*ADR_W-1:0] i_wb_m_adr,
    input  logic [NUM_M*DAT_W-1:0] i_wb_m_dat,
    input  logic [NUM_M*SEL_W-1:0] i_wb_m_sel,
    input  logic [NUM_M-1:0]       i_wb_m_we,
    input  logic [NUM_M-1:0]       i_wb_m_stb,
    output logic [DAT_W-1:0]       o_wb_m_rdt,
    output logic [NUM_M-1:0]       o_wb_m_ack,
    output logic [NUM_M-1:0]       o_wb_m_err,
    output logic [ADR_W-1:0]       o_wb_s_adr,
    output logic [DAT_W-1:0]       o_wb_s_dat,
    output logic [SEL_W-1:0]       o_wb_s_sel,
    output logic                   o_wb_s_we,
    output logic                   o_wb_s_stb,
    input  logic [DAT_W-1:0]       i_wb_s_rdt,
    input  logic                   i_wb_s_ack,
    output logic [NUM_M-1:0]       o_grant
);

    localparam int unsigned   PW = ptr_w(NUM_M);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    state_e           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic [NUM_M-1:0] pick_gnt;
    logic [PW-1:0]    gidx;
    logic             gstb;
    logic             busy;
    logic             timeout_hit;

    servile_rr_pick #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_pick (
        .req_i (i_wb_m_stb),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    assign busy        = (state_q == ST_BUSY);
    assign gstb        = |(i_wb_m_stb & grant_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO);

    always_comb begin
        gidx = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (grant_q[k]) begin
                gidx = PW'(k);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(NUM_M - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|i_wb_m_stb) begin
                    grant_d = pick_gnt;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack, master abort and timeout all end the transaction the
                // same way; they differ only in which response is emitted.
                if (i_wb_s_ack || !gstb || timeout_hit) begin
                    grant_d = '0;
                    ptr_d   = gidx;
                    state_d = ST_IDLE;
                end else if (cnt_q != TO) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: grant_q is zero outside BUSY, so the AND-OR mux yields zero
    // in IDLE without extra gating.
    always_comb begin
        o_wb_s_adr = '0;
        o_wb_s_dat = '0;
        o_wb_s_sel = '0;
        o_wb_s_we  = 1'b0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            o_wb_s_adr = o_wb_s_adr | ({ADR_W{grant_q[k]}} & i_wb_m_adr[k*ADR_W +: ADR_W]);
            o_wb_s_dat = o_wb_s_dat | ({DAT_W{grant_q[k]}} & i_wb_m_dat[k*DAT_W +: DAT_W]);
            o_wb_s_sel = o_wb_s_sel | ({SEL_W{grant_q[k]}} & i_wb_m_sel[k*SEL_W +: SEL_W]);
            o_wb_s_we  = o_wb_s_we  | (grant_q[k] & i_wb_m_we[k]);
        end
        o_wb_s_stb = busy && gstb;
        o_wb_m_rdt = i_wb_s_rdt;
        o_wb_m_ack = (busy && i_wb_s_ack) ? grant_q : '0;
        o_wb_m_err = (busy && !i_wb_s_ack && gstb && timeout_hit) ? grant_q : '0;
        o_grant    = grant_q;
    end

endmodule

// File: tb/tb_servile_wb_rr_arbiter.sv
module tb_servile_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] m_adr;
    logic [95:0] m_dat;
    logic [11:0] m_sel;
    logic [2:0]  m_we;
    logic [2:0]  m_stb;
    logic [31:0] m_rdt;
    logic [2:0]  m_ack;
    logic [2:0]  m_err;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    logic        s_stb;
    logic [31:0] s_rdt;
    logic        s_ack;
    logic [2:0]  grant;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    servile_wb_rr_arbiter #(
        .NUM_M   (3),
        .TIMEOUT (4),
        .CW      (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_m_adr (m_adr),
        .i_wb_m_dat (m_dat),
        .i_wb_m_sel (m_sel),
        .i_wb_m_we  (m_we),
        .i_wb_m_stb (m_stb),
        .o_wb_m_rdt (m_rdt),
        .o_wb_m_ack (m_ack),
        .o_wb_m_err (m_err),
        .o_wb_s_adr (s_adr),
        .o_wb_s_dat (s_dat),
        .o_wb_s_sel (s_sel),
        .o_wb_s_we  (s_we),
        .o_wb_s_stb (s_stb),
        .i_wb_s_rdt (s_rdt),
        .i_wb_s_ack (s_ack),
        .o_grant    (grant)
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_adr = {32'h300, 32'h200, 32'h100};
        m_dat = {32'hCCCC_0003, 32'hBBBB_0002, 32'h1122_3344};
        m_sel = {4'b1000, 4'b0011, 4'b0101};
        m_we  = 3'b001;
        m_stb = 3'b001;
        s_rdt = 32'hDEAD_BEEF;
        s_ack = 1'b0;
        cyc();
        cyc();
        #1;
        tests++; if (grant !== 3'b000) begin failed++; $display("FAIL reset_grant got %b exp %b", grant, 3'b000); end
        tests++; if (s_stb !== 1'b0) begin failed++; $display("FAIL reset_s_stb got %b exp 0", s_stb); end
        tests++; if (s_adr !== 32'h0) begin failed++; $display("FAIL reset_s_adr got %h exp 0", s_adr); end
        tests++; if (m_ack !== 3'b000 || m_err !== 3'b000) begin failed++; $display("FAIL reset_ack_err got ack %b err %b exp 000/000", m_ack, m_err); end
        tests++; if (m_rdt !== 32'hDEAD_BEEF) begin failed++; $display("FAIL reset_rdt got %h exp deadbeef", m_rdt); end
    endtask

    task automatic test_single();
        cyc();
        rst_n = 1'b1;
        #1;
        tests++; if (s_stb !== 1'b0) begin failed++; $display("FAIL single_idle_stb got %b exp 0", s_stb); end
        cyc();
        #1;
        tests++; if (grant !== 3'b001) begin failed++; $display("FAIL single_grant got %b exp 001", grant); end
        tests++; if (s_adr !== 32'h100 || s_stb !== 1'b1) begin failed++; $display("FAIL single_adr_stb got %h/%b exp 100/1", s_adr, s_stb); end
        tests++; if (s_dat !== 32'h1122_3344 || s_sel !== 4'b0101 || s_we !== 1'b1) begin failed++; $display("FAIL single_dat_sel_we got %h/%b/%b exp 11223344/0101/1", s_dat, s_sel, s_we); end
        tests++; if (m_ack !== 3'b000) begin failed++; $display("FAIL single_early_ack got %b exp 000", m_ack); end
        cyc();
        s_ack = 1'b1;
        #1;
        tests++; if (m_ack !== 3'b001 || m_err !== 3'b000) begin failed++; $display("FAIL single_ack got ack %b err %b exp 001/000", m_ack, m_err); end
        cyc();
        m_stb = 3'b000;
        #1;
        tests++; if (grant !== 3'b000 || s_stb !== 1'b0) begin failed++; $display("FAIL single_after got grant %b stb %b exp 000/0", grant, s_stb); end
        tests++; if (m_ack !== 3'b000) begin failed++; $display("FAIL idle_ack_ignored got %b exp 000", m_ack); end
        s_ack = 1'b0;
    endtask

    task automatic test_fairness();
        logic [2:0]  e;
        logic [31:0] ea;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_stb = 3'b111;
        #1;
        tests++; if (s_stb !== 1'b0) begin failed++; $display("FAIL fair_idle_stb got %b exp 0", s_stb); end
        for (int t = 0; t < 6; t++) begin
            e  = 3'b001 << (t % 3);
            ea = 32'h100 * ((t % 3) + 1);
            cyc();
            s_ack = 1'b1;
            #1;
            tests++; if (grant !== e || m_ack !== e) begin failed++; $display("FAIL fair_grant_%0d got grant %b ack %b exp %b", t, grant, m_ack, e); end
            tests++; if (s_adr !== ea || s_stb !== 1'b1) begin failed++; $display("FAIL fair_adr_%0d got %h/%b exp %h/1", t, s_adr, s_stb, ea); end
            cyc();
            s_ack = 1'b0;
            #1;
            tests++; if (s_stb !== 1'b0 || grant !== 3'b000) begin failed++; $display("FAIL fair_gap_%0d got stb %b grant %b exp 0/000", t, s_stb, grant); end
        end
        m_stb = 3'b000;
    endtask

    task automatic test_back_to_back();
        m_stb = 3'b010;
        cyc();
        s_ack = 1'b1;
        #1;
        tests++; if (grant !== 3'b010 || m_ack !== 3'b010) begin failed++; $display("FAIL b2b_m1 got grant %b ack %b exp 010/010", grant, m_ack); end
        cyc();
        s_ack = 1'b0;
        m_stb = 3'b011;
        #1;
        tests++; if (s_stb !== 1'b0) begin failed++; $display("FAIL b2b_gap got %b exp 0", s_stb); end
        cyc();
        s_ack = 1'b1;
        #1;
        tests++; if (grant !== 3'b001 || m_ack !== 3'b001) begin failed++; $display("FAIL b2b_m0_first got grant %b ack %b exp 001/001", grant, m_ack); end
        cyc();
        s_ack = 1'b0;
        m_stb = 3'b010;
        #1;
        cyc();
        s_ack = 1'b1;
        #1;
        tests++; if (grant !== 3'b010 || m_ack !== 3'b010) begin failed++; $display("FAIL b2b_m1_second got grant %b ack %b exp 010/010", grant, m_ack); end
        cyc();
        s_ack = 1'b0;
        m_stb = 3'b000;
        #1;
    endtask

    task automatic test_timeout();
        int errs = 0;
        m_stb = 3'b011;
        for (int b = 1; b <= 5; b++) begin
            cyc();
            #1;
            if (m_err !== 3'b000) errs++;
            tests++; if (m_err !== ((b == 5) ? 3'b001 : 3'b000)) begin failed++; $display("FAIL timeout_err_cyc%0d got %b exp %b", b, m_err, (b == 5) ? 3'b001 : 3'b000); end
            tests++; if (grant !== 3'b001 || m_ack !== 3'b000) begin failed++; $display("FAIL timeout_busy_cyc%0d got grant %b ack %b exp 001/000", b, grant, m_ack); end
        end
        cyc();
        m_stb = 3'b010;
        #1;
        if (m_err !== 3'b000) errs++;
        tests++; if (s_stb !== 1'b0 || grant !== 3'b000) begin failed++; $display("FAIL timeout_release got stb %b grant %b exp 0/000", s_stb, grant); end
        tests++; if (errs !== 1) begin failed++; $display("FAIL timeout_pulse_count got %0d exp 1", errs); end
        cyc();
        s_ack = 1'b1;
        #1;
        tests++; if (grant !== 3'b010 || m_ack !== 3'b010) begin failed++; $display("FAIL timeout_next_master got grant %b ack %b exp 010/010", grant, m_ack); end
        cyc();
        s_ack = 1'b0;
        m_stb = 3'b000;
        #1;
    endtask

    task automatic test_ack_at_timeout();
        m_stb = 3'b001;
        for (int b = 1; b <= 5; b++) begin
            cyc();
            if (b == 5) s_ack = 1'b1;
            #1;
        end
        tests++; if (m_ack !== 3'b001 || m_err !== 3'b000) begin failed++; $display("FAIL ack_at_timeout got ack %b err %b exp 001/000", m_ack, m_err); end
        cyc();
        m_stb = 3'b000;
        s_ack = 1'b0;
        #1;
        tests++; if (grant !== 3'b000 || m_err !== 3'b000) begin failed++; $display("FAIL ack_at_timeout_after got grant %b err %b exp 000/000", grant, m_err); end
    endtask

    task automatic test_abort();
        m_stb = 3'b010;
        cyc();
        #1;
        tests++; if (grant !== 3'b010 || s_adr !== 32'h200) begin failed++; $display("FAIL abort_grant got %b/%h exp 010/200", grant, s_adr); end
        cyc();
        m_stb = 3'b000;
        #1;
        tests++; if (s_stb !== 1'b0 || m_ack !== 3'b000 || m_err !== 3'b000) begin failed++; $display("FAIL abort_resp got stb %b ack %b err %b exp 0/000/000", s_stb, m_ack, m_err); end
        cyc();
        #1;
        tests++; if (grant !== 3'b000) begin failed++; $display("FAIL abort_idle got %b exp 000", grant); end
    endtask

    task automatic test_reset_mid_busy();
        m_stb = 3'b100;
        cyc();
        #1;
        tests++; if (grant !== 3'b100 || s_stb !== 1'b1) begin failed++; $display("FAIL rstbusy_grant got %b/%b exp 100/1", grant, s_stb); end
        rst_n = 1'b0;
        m_stb = 3'b111;
        cyc();
        #1;
        tests++; if (grant !== 3'b000 || s_stb !== 1'b0 || m_ack !== 3'b000 || m_err !== 3'b000) begin failed++; $display("FAIL rstbusy_drop got grant %b stb %b ack %b err %b exp 000/0/000/000", grant, s_stb, m_ack, m_err); end
        rst_n = 1'b1;
        cyc();
        #1;
        tests++; if (grant !== 3'b001) begin failed++; $display("FAIL rstbusy_m0_first got %b exp 001", grant); end
        m_stb = 3'b000;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_abort();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
